// File: rtl/operand_issue_pkg.sv
//------------------------------------------------------------------------------
// operand_issue_pkg : shared widths, ALU opcodes and operand-select encodings
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package operand_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic OPA_RS1 = 1'b0;
  localparam logic OPA_PC  = 1'b1;
  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  // Register x0 is hard-wired zero, so a pending write to it never forwards.
  function automatic logic fwd_hit(input logic wen, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return wen && (rd == rs) && (rd != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_issue_if.sv
//------------------------------------------------------------------------------
// operand_issue_if : decode-side and ALU-side valid/ready bundles
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface operand_issue_if #(
  parameter int XLEN = operand_issue_pkg::XLEN
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            opa_sel;
  logic            opb_sel;
  logic [3:0]      alu_sel_in;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [3:0]      aluOutSel;
  logic [4:0]      rd_addr_out;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr_in, rs1_data, rs2_data,
           pc, imm, opa_sel, opb_sel, alu_sel_in, out_ready,
    input  in_ready, out_valid, opA, opB, aluOutSel, rd_addr_out
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr_in, rs1_data, rs2_data,
           pc, imm, opa_sel, opb_sel, alu_sel_in, out_ready,
    output in_ready, out_valid, opA, opB, aluOutSel, rd_addr_out
  );
endinterface

`default_nettype wire

// File: rtl/operand_issue_fwd_mux.sv
//------------------------------------------------------------------------------
// fwd_mux : EX/MEM-over-WB bypass selection for one source operand
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fwd_mux #(
  parameter int XLEN = operand_issue_pkg::XLEN
) (
  input  wire logic [4:0]      rs_addr_i,
  input  wire logic [XLEN-1:0] rs_data_i,
  input  wire logic            exm_wen_i,
  input  wire logic [4:0]      exm_rd_i,
  input  wire logic [XLEN-1:0] exm_data_i,
  input  wire logic            wb_wen_i,
  input  wire logic [4:0]      wb_rd_i,
  input  wire logic [XLEN-1:0] wb_data_i,
  output logic      [XLEN-1:0] fwd_data_o
);
  import operand_issue_pkg::*;

  always_comb begin
    fwd_data_o = rs_data_i;
    if (fwd_hit(exm_wen_i, exm_rd_i, rs_addr_i)) begin
      fwd_data_o = exm_data_i;
    end else if (fwd_hit(wb_wen_i, wb_rd_i, rs_addr_i)) begin
      fwd_data_o = wb_data_i;
    end
  end
endmodule

`default_nettype wire

// File: rtl/operand_issue.sv
//------------------------------------------------------------------------------
// operand_issue : one-entry operand pipeline register with bypass and stall count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module operand_issue #(
  parameter int XLEN  = operand_issue_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  operand_issue_if.slave       io,
  input  wire logic            exm_wen,
  input  wire logic [4:0]      exm_rd,
  input  wire logic [XLEN-1:0] exm_data,
  input  wire logic            wb_wen,
  input  wire logic [4:0]      wb_rd,
  input  wire logic [XLEN-1:0] wb_data,
  input  wire logic            flush,
  output logic      [CNT_W-1:0] stall_cnt
);
  import operand_issue_pkg::*;

  issue_state_e    state_q, state_d;
  logic [XLEN-1:0] opa_q, opb_q;
  logic [3:0]      alu_q;
  logic [4:0]      rd_q;
  logic [CNT_W-1:0] stall_q;

  logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd;
  logic            w_capture, w_stalled;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr_i (io.rs1_addr), .rs_data_i (io.rs1_data),
    .exm_wen_i (exm_wen), .exm_rd_i (exm_rd), .exm_data_i (exm_data),
    .wb_wen_i  (wb_wen),  .wb_rd_i  (wb_rd),  .wb_data_i  (wb_data),
    .fwd_data_o(w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr_i (io.rs2_addr), .rs_data_i (io.rs2_data),
    .exm_wen_i (exm_wen), .exm_rd_i (exm_rd), .exm_data_i (exm_data),
    .wb_wen_i  (wb_wen),  .wb_rd_i  (wb_rd),  .wb_data_i  (wb_data),
    .fwd_data_o(w_rs2_fwd)
  );

  assign io.in_ready = (state_q == ST_EMPTY) || io.out_ready;
  assign w_capture   = io.in_valid && io.in_ready;
  assign w_stalled   = (state_q == ST_FULL) && !io.out_ready;

  // Flush outranks everything, including a capture in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (w_capture) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && io.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      opa_q   <= '0;
      opb_q   <= '0;
      alu_q   <= 4'b0000;
      rd_q    <= 5'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_capture) begin
        opa_q <= (io.opa_sel == OPA_PC)  ? io.pc  : w_rs1_fwd;
        opb_q <= (io.opb_sel == OPB_IMM) ? io.imm : w_rs2_fwd;
        alu_q <= io.alu_sel_in;
        rd_q  <= io.rd_addr_in;
      end
      if (w_stalled && !flush && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign io.out_valid   = (state_q == ST_FULL);
  assign io.opA         = opa_q;
  assign io.opB         = opb_q;
  assign io.aluOutSel   = alu_q;
  assign io.rd_addr_out = rd_q;
  assign stall_cnt      = stall_q;
endmodule

`default_nettype wire

// File: tb/tb_operand_issue.sv
//------------------------------------------------------------------------------
// tb_operand_issue : directed vectors with a queue scoreboard and output monitor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_issue;
  logic        clk;
  logic        rst_n;
  logic        exm_wen, wb_wen, flush;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic [15:0] stall_cnt;

  operand_issue_if #(.XLEN(32)) io ();

  operand_issue #(.XLEN(32), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (io),
    .exm_wen  (exm_wen),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out opA=%h opB=%h alu=%h rd=%0d, none expected",
                 io.opA, io.opB, io.aluOutSel, io.rd_addr_out);
      end else begin
        if ({io.opA, io.opB, io.aluOutSel, io.rd_addr_out} !==
            {exp_q[0].a, exp_q[0].b, exp_q[0].alu, exp_q[0].rd}) begin
          n_bad++;
          $display("FAIL vec%0d got opA=%h opB=%h alu=%h rd=%0d want opA=%h opB=%h alu=%h rd=%0d",
                   exp_q[0].id, io.opA, io.opB, io.aluOutSel, io.rd_addr_out,
                   exp_q[0].a, exp_q[0].b, exp_q[0].alu, exp_q[0].rd);
        end
        if (io.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                     input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    exm_wen = ew; exm_rd = er; exm_data = ed;
    wb_wen  = ww; wb_rd  = wr; wb_data  = wd;
  endtask

  task automatic set_in(input logic [4:0] r1a, input logic [31:0] r1d,
                        input logic [4:0] r2a, input logic [31:0] r2d,
                        input logic [31:0] pcv, input logic [31:0] immv,
                        input logic sa, input logic sb, input logic [3:0] alu,
                        input logic [4:0] rd);
    io.rs1_addr = r1a; io.rs1_data = r1d;
    io.rs2_addr = r2a; io.rs2_data = r2d;
    io.pc = pcv; io.imm = immv;
    io.opa_sel = sa; io.opb_sel = sb;
    io.alu_sel_in = alu; io.rd_addr_in = rd;
    io.in_valid = 1'b1;
  endtask

  task automatic expect_out(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] alu, input logic [4:0] rd);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.alu = alu; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0;
    io.out_ready = 1'b1;
    io.in_valid = 1'b0;
    set_in(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 5'd0);
    io.in_valid = 1'b0;
    fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_opA", io.opA, 32'd0);
    chk("rst_opB", io.opB, 32'd0);
    chk("rst_alu", {28'd0, io.aluOutSel}, 32'd0);
    chk("rst_rd", {27'd0, io.rd_addr_out}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);

    // Release between edges; first capture on the very next rising edge.
    @(negedge clk); #1 rst_n = 1'b1;
    set_in(5'd1, 32'd5, 5'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0000, 5'd10);
    expect_out(1, 32'd5, 32'd1, 4'b0000, 5'd10);
    step();
    chk("first_capture_valid", {31'd0, io.out_valid}, 32'd1);

    fwd(1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 32'd9);
    set_in(5'd3, 32'd1, 5'd4, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0010, 5'd11);
    expect_out(2, 32'd7, 32'd2, 4'b0010, 5'd11);
    step();

    fwd(1'b0, 5'd3, 32'd7, 1'b1, 5'd3, 32'd9);
    set_in(5'd3, 32'd1, 5'd4, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0011, 5'd12);
    expect_out(3, 32'd9, 32'd2, 4'b0011, 5'd12);
    step();

    fwd(1'b1, 5'd0, 32'd33, 1'b1, 5'd0, 32'd44);
    set_in(5'd0, 32'd11, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0100, 5'd13);
    expect_out(4, 32'd11, 32'd0, 4'b0100, 5'd13);
    step();

    fwd(1'b1, 5'd8, 32'hAAAA_0008, 1'b1, 5'd7, 32'h55);
    set_in(5'd8, 32'd1, 5'd7, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0101, 5'd14);
    expect_out(5, 32'hAAAA_0008, 32'h55, 4'b0101, 5'd14);
    step();

    fwd(1'b1, 5'd3, 32'd7, 1'b1, 5'd4, 32'd9);
    set_in(5'd3, 32'd1, 5'd4, 32'd2, 32'h100, 32'hFFFF_FFFC, 1'b1, 1'b1, 4'b0001, 5'd15);
    expect_out(6, 32'h100, 32'hFFFF_FFFC, 4'b0001, 5'd15);
    step();
    io.in_valid = 1'b0;
    fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    // Back-pressure: A is captured and held, B waits four cycles then replaces A.
    io.out_ready = 1'b0;
    set_in(5'd1, 32'h1111, 5'd2, 32'h2222, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0110, 5'd16);
    expect_out(7, 32'h1111, 32'h2222, 4'b0110, 5'd16);
    step();
    set_in(5'd1, 32'h3333, 5'd2, 32'h4444, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0111, 5'd17);
    expect_out(8, 32'h3333, 32'h4444, 4'b0111, 5'd17);
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", {31'd0, io.in_ready}, 32'd0);
      step();
    end
    chk("stall_cnt_4", {16'd0, stall_cnt}, 32'd4);
    io.out_ready = 1'b1;
    #1 chk("drain_in_ready", {31'd0, io.in_ready}, 32'd1);
    step();
    io.in_valid = 1'b0;
    chk("no_bubble_valid", {31'd0, io.out_valid}, 32'd1);
    step();
    chk("drained_valid", {31'd0, io.out_valid}, 32'd0);

    // Flush beats a same-cycle capture.
    set_in(5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1000, 5'd18);
    flush = 1'b1;
    step();
    flush = 1'b0; io.in_valid = 1'b0;
    chk("flush_capture_valid", {31'd0, io.out_valid}, 32'd0);

    // Flush of a held entry leaves the stall count untouched.
    io.out_ready = 1'b0;
    set_in(5'd1, 32'h5A5A, 5'd2, 32'hA5A5, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1001, 5'd19);
    expect_out(9, 32'h5A5A, 32'hA5A5, 4'b1001, 5'd19);
    step();
    io.in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_held_valid", {31'd0, io.out_valid}, 32'd0);
    chk("flush_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // Reset while full drops the entry immediately.
    set_in(5'd1, 32'h7777, 5'd2, 32'h8888, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0011, 5'd20);
    expect_out(10, 32'h7777, 32'h8888, 4'b0011, 5'd20);
    step();
    io.in_valid = 1'b0;
    step();
    chk("pre_rst_stall", {16'd0, stall_cnt}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_valid", {31'd0, io.out_valid}, 32'd0);
    chk("midrst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("midrst_opA", io.opA, 32'd0);
    chk("midrst_in_ready", {31'd0, io.in_ready}, 32'd1);
    @(negedge clk); #1 rst_n = 1'b1;
    io.out_ready = 1'b1;
    set_in(5'd9, 32'h0BAD_F00D, 5'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0010, 5'd21);
    expect_out(11, 32'h0BAD_F00D, 32'd3, 4'b0010, 5'd21);
    step();
    io.in_valid = 1'b0;
    chk("post_rst_capture", {31'd0, io.out_valid}, 32'd1);
    step();
    step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
